// File: rtl/ddr_arb_pkg.sv
// Shared types and constants for the DDR port arbiter and its round-robin core.
package ddr_arb_pkg;

    // Transaction sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam int DEF_NUM_CLIENTS = 3;
    localparam int DEF_ADDR_WIDTH  = 28;
    localparam int DEF_DATA_WIDTH  = 128;
    localparam int DEF_TIMEOUT_CYC = 64;

    // Width needed to hold values 0..value-1; never less than one bit so that
    // degenerate parameterisations still produce legal vectors.
    function automatic int ddr_arb_clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/ddr_port_arbiter_rr.sv
// Combinational round-robin picker: the first requester strictly after the
// pointer (wrapping) wins. Produces both a one-hot grant and its index.
module rr_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int N     = 3,
    parameter int IDX_W = ddr_arb_clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_req
);

    logic             found_s;
    logic             hit_s;
    logic [IDX_W-1:0] cand_s;

    // Index of the client 'off' positions after 'base', modulo N.
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                  input int off);
        int s;
        s = int'(base) + off;
        if (s >= N) begin
            s = s - N;
        end else begin
            s = s;
        end
        return s[IDX_W-1:0];
    endfunction

    assign any_req = |req;

    // Scan clients starting just after the pointer; the lowest offset wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        hit_s     = 1'b0;
        cand_s    = '0;
        for (int k = 1; k <= N; k++) begin
            cand_s = wrap_idx(ptr, k);
            hit_s  = req[cand_s] & ~found_s;
            if (hit_s) begin
                grant[cand_s] = 1'b1;
                grant_idx     = cand_s;
                found_s       = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/ddr_port_arbiter.sv
// Shares one mem_req/mem_ack port of the DDR controller between several
// requesters. One transaction in flight at a time, round-robin fairness,
// optional timeout that completes the transaction with an error flag.
module ddr_port_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int  NUM_CLIENTS = DEF_NUM_CLIENTS,
    parameter int  ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int  DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int  TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    localparam int IDX_W       = ddr_arb_clog2(NUM_CLIENTS)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CLIENTS-1:0]            c_req,
    input  logic [NUM_CLIENTS-1:0]            c_we,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] c_addr,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] c_wdata,
    output logic [NUM_CLIENTS-1:0]            c_ack,
    output logic                              c_err,
    output logic [DATA_WIDTH-1:0]             c_rdata,
    output logic                              mem_req,
    output logic                              mem_we,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [DATA_WIDTH-1:0]             mem_wdata,
    input  logic [DATA_WIDTH-1:0]             mem_rdata,
    input  logic                              mem_ack,
    output logic                              busy,
    output logic [IDX_W-1:0]                  grant_id
);

    localparam int               CNT_W    = ddr_arb_clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);
    localparam logic             TO_EN    = (TIMEOUT_CYC != 0);
    // Pointer starts at the last client so client 0 is the first winner.
    localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(NUM_CLIENTS - 1);

    arb_state_e state_r;
    arb_state_e next_state_s;

    logic [IDX_W-1:0]       ptr_r;
    logic [NUM_CLIENTS-1:0] arb_grant_s;
    logic [IDX_W-1:0]       arb_idx_s;
    logic                   arb_any_s;

    logic                   latch_s;
    logic                   take_ack_s;
    logic                   take_to_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_next_s;

    logic                   sel_we_s;
    logic [ADDR_WIDTH-1:0]  sel_addr_s;
    logic [DATA_WIDTH-1:0]  sel_wdata_s;
    logic [NUM_CLIENTS-1:0] ack_vec_s;

    logic [NUM_CLIENTS-1:0] c_ack_r;
    logic                   c_err_r;
    logic [DATA_WIDTH-1:0]  c_rdata_r;
    logic                   mem_req_r;
    logic                   mem_we_r;
    logic [ADDR_WIDTH-1:0]  mem_addr_r;
    logic [DATA_WIDTH-1:0]  mem_wdata_r;
    logic                   busy_r;
    logic [IDX_W-1:0]       grant_id_r;

    rr_arbiter #(
        .N     (NUM_CLIENTS),
        .IDX_W (IDX_W)
    ) u_rr (
        .req       (c_req),
        .ptr       (ptr_r),
        .grant     (arb_grant_s),
        .grant_idx (arb_idx_s),
        .any_req   (arb_any_s)
    );

    // One-hot AND-OR select of the winning client's command fields.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            sel_we_s    = sel_we_s | (arb_grant_s[i] & c_we[i]);
            sel_addr_s  = sel_addr_s  | ({ADDR_WIDTH{arb_grant_s[i]}} & c_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
            sel_wdata_s = sel_wdata_s | ({DATA_WIDTH{arb_grant_s[i]}} & c_wdata[i*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    // Next-state logic plus datapath strobes; mem_ack outside ISSUE/WAIT is ignored.
    always_comb begin
        next_state_s = state_r;
        latch_s      = 1'b0;
        take_ack_s   = 1'b0;
        take_to_s    = 1'b0;
        cnt_next_s   = '0;
        case (state_r)
            IDLE: begin
                if (arb_any_s) begin
                    latch_s      = 1'b1;
                    next_state_s = ISSUE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ISSUE: begin
                if (mem_ack) begin
                    take_ack_s   = 1'b1;
                    next_state_s = RESP;
                end else begin
                    next_state_s = WAIT;
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    take_ack_s   = 1'b1;
                    next_state_s = RESP;
                end else if (TO_EN && (cnt_r == CNT_LAST)) begin
                    take_to_s    = 1'b1;
                    next_state_s = RESP;
                end else begin
                    cnt_next_s   = cnt_r + CNT_W'(1);
                    next_state_s = WAIT;
                end
            end
            RESP: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Decode the latched grant index into the completion pulse vector.
    always_comb begin
        ack_vec_s             = '0;
        ack_vec_s[grant_id_r] = 1'b1;
    end

    // State register and timeout counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Registered control outputs, decoded from the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req_r <= 1'b0;
            busy_r    <= 1'b0;
            c_ack_r   <= '0;
        end else begin
            mem_req_r <= (next_state_s == ISSUE);
            busy_r    <= (next_state_s != IDLE);
            c_ack_r   <= (next_state_s == RESP) ? ack_vec_s : '0;
        end
    end

    // Command latch and round-robin pointer update on each grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            grant_id_r  <= '0;
            ptr_r       <= PTR_RST;
        end else if (latch_s) begin
            mem_we_r    <= sel_we_s;
            mem_addr_r  <= sel_addr_s;
            mem_wdata_r <= sel_wdata_s;
            grant_id_r  <= arb_idx_s;
            ptr_r       <= arb_idx_s;
        end else begin
            mem_we_r    <= mem_we_r;
            mem_addr_r  <= mem_addr_r;
            mem_wdata_r <= mem_wdata_r;
            grant_id_r  <= grant_id_r;
            ptr_r       <= ptr_r;
        end
    end

    // Response capture: controller data on ack, zero plus error on timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            c_rdata_r <= '0;
            c_err_r   <= 1'b0;
        end else if (take_ack_s) begin
            c_rdata_r <= mem_rdata;
            c_err_r   <= 1'b0;
        end else if (take_to_s) begin
            c_rdata_r <= '0;
            c_err_r   <= 1'b1;
        end else begin
            c_rdata_r <= c_rdata_r;
            c_err_r   <= c_err_r;
        end
    end

    assign c_ack     = c_ack_r;
    assign c_err     = c_err_r;
    assign c_rdata   = c_rdata_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign busy      = busy_r;
    assign grant_id  = grant_id_r;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Directed bench for ddr_port_arbiter with a small DDR controller model.
module tb_ddr_port_arbiter;

    localparam int NC = 3;
    localparam int AW = 28;
    localparam int DW = 128;
    localparam int TO = 8;

    logic              clk;
    logic              reset;
    logic [NC-1:0]     c_req;
    logic [NC-1:0]     c_we;
    logic [NC*AW-1:0]  c_addr;
    logic [NC*DW-1:0]  c_wdata;
    logic [NC-1:0]     c_ack;
    logic              c_err;
    logic [DW-1:0]     c_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;
    logic              mem_ack;
    logic              busy;
    logic [1:0]        grant_id;

    ddr_port_arbiter #(
        .NUM_CLIENTS (NC),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .c_req     (c_req),
        .c_we      (c_we),
        .c_addr    (c_addr),
        .c_wdata   (c_wdata),
        .c_ack     (c_ack),
        .c_err     (c_err),
        .c_rdata   (c_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total_cnt = 0;
    int bad_cnt   = 0;

    // model / monitor state (written only by the model process)
    int            cyc = 0;
    int            req_cnt = 0;
    int            req_cyc = 0;
    int            ack_cyc = 0;
    int            cack_cyc = 0;
    int            pend = 0;
    int            stray_done = 0;
    logic          last_we = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] last_wdata = '0;
    logic [DW-1:0] pend_rd = '0;
    logic [DW-1:0] store [logic [AW-1:0]];

    // controls written only by the main process
    int ack_delay = 2;
    int stray_req = 0;

    localparam logic [AW-1:0] ADDR_A  = 28'h000000A;
    localparam logic [DW-1:0] WDATA_A = 128'hDEADBEEF_01234567_89ABCDEF_13572468;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // DDR controller model and output monitor, sampling on the falling edge.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            mem_ack = 1'b0;
            if (stray_req != stray_done) begin
                mem_ack    = 1'b1;
                stray_done = stray_req;
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = pend_rd;
                    ack_cyc   = cyc;
                end
            end
            if (mem_req) begin
                req_cnt++;
                req_cyc    = cyc;
                last_we    = mem_we;
                last_addr  = mem_addr;
                last_wdata = mem_wdata;
                if (mem_we) begin
                    store[mem_addr] = mem_wdata;
                    pend_rd = '0;
                end else if (store.exists(mem_addr)) begin
                    pend_rd = store[mem_addr];
                end else begin
                    pend_rd = '0;
                end
                if (ack_delay > 0) pend = ack_delay;
            end
            if (c_ack != '0) cack_cyc = cyc;
            if (reset) pend = 0;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input int idx, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata);
        c_we[idx]              = we;
        c_addr[idx*AW +: AW]   = addr;
        c_wdata[idx*DW +: DW]  = wdata;
        c_req[idx]             = 1'b1;
    endtask

    // Wait (bounded) for a completion pulse, drop that client's request,
    // then confirm the pulse lasted a single cycle.
    task automatic wait_ack(input string tag, output int idx);
        idx = -1;
        for (int n = 0; n < 60; n++) begin
            step();
            if (c_ack != '0) break;
        end
        chk({tag, "_seen"}, {127'b0, (c_ack != '0)}, 128'd1);
        if (c_ack != '0) begin
            chk({tag, "_onehot"}, 128'($countones(c_ack)), 128'd1);
            for (int i = 0; i < NC; i++) begin
                if (c_ack[i]) idx = i;
            end
            if (idx >= 0) c_req[idx] = 1'b0;
            step();
            chk({tag, "_pulse"}, {125'b0, c_ack}, 128'd0);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_mem_req"},   {127'b0, mem_req}, 128'd0);
        chk({tag, "_busy"},      {127'b0, busy}, 128'd0);
        chk({tag, "_c_ack"},     {125'b0, c_ack}, 128'd0);
        chk({tag, "_c_err"},     {127'b0, c_err}, 128'd0);
        chk({tag, "_c_rdata"},   c_rdata, 128'd0);
        chk({tag, "_mem_we"},    {127'b0, mem_we}, 128'd0);
        chk({tag, "_mem_addr"},  {100'b0, mem_addr}, 128'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 128'd0);
        chk({tag, "_grant_id"},  {126'b0, grant_id}, 128'd0);
    endtask

    initial begin
        int idx;
        int start_cyc;
        int base_req;
        int seen;

        reset   = 1'b1;
        c_req   = '0;
        c_we    = '0;
        c_addr  = '0;
        c_wdata = '0;
        repeat (3) step();
        chk_zero_outputs("rst");
        reset = 1'b0;
        step();

        // single write from client 1, controller acks two cycles after mem_req
        base_req  = req_cnt;
        start_cyc = cyc;
        drive(1, 1'b1, ADDR_A, WDATA_A);
        wait_ack("wr", idx);
        chk("wr_client",   128'(idx), 128'd1);
        chk("wr_err",      {127'b0, c_err}, 128'd0);
        chk("wr_nreq",     128'(req_cnt - base_req), 128'd1);
        chk("wr_we",       {127'b0, last_we}, 128'd1);
        chk("wr_addr",     {100'b0, last_addr}, {100'b0, ADDR_A});
        chk("wr_wdata",    last_wdata, WDATA_A);
        chk("wr_req_lat",  128'(req_cyc - start_cyc), 128'd1);
        chk("wr_ack_lat",  128'(cack_cyc - ack_cyc), 128'd1);
        chk("wr_total",    128'(cack_cyc - start_cyc), 128'd4);
        chk("wr_grant_id", {126'b0, grant_id}, 128'd1);

        // read back the same address from client 1
        base_req = req_cnt;
        drive(1, 1'b0, ADDR_A, '0);
        wait_ack("rd", idx);
        chk("rd_client", 128'(idx), 128'd1);
        chk("rd_rdata",  c_rdata, WDATA_A);
        chk("rd_we",     {127'b0, last_we}, 128'd0);
        chk("rd_nreq",   128'(req_cnt - base_req), 128'd1);
        chk("rd_hold",   {100'b0, mem_addr}, {100'b0, ADDR_A});

        // fresh reset so the pointer restarts at client 0
        reset = 1'b1;
        step();
        reset = 1'b0;

        // three simultaneous requesters, then clients 0 and 2 again
        base_req = req_cnt;
        drive(0, 1'b1, 28'h0000100, 128'h100);
        drive(1, 1'b1, 28'h0000200, 128'h200);
        drive(2, 1'b1, 28'h0000300, 128'h300);
        wait_ack("c0", idx);
        chk("cont_1st", 128'(idx), 128'd0);
        wait_ack("c1", idx);
        chk("cont_2nd", 128'(idx), 128'd1);
        wait_ack("c2", idx);
        chk("cont_3rd", 128'(idx), 128'd2);
        drive(0, 1'b0, 28'h0000300, '0);
        drive(2, 1'b0, 28'h0000100, '0);
        wait_ack("c3", idx);
        chk("cont_4th", 128'(idx), 128'd0);
        chk("cont_4th_data", c_rdata, 128'h300);
        wait_ack("c4", idx);
        chk("cont_5th", 128'(idx), 128'd2);
        chk("cont_5th_data", c_rdata, 128'h100);
        chk("cont_nreq", 128'(req_cnt - base_req), 128'd5);

        // timeout: controller never answers
        ack_delay = -1;
        drive(2, 1'b0, 28'h0000300, '0);
        wait_ack("to", idx);
        chk("to_client", 128'(idx), 128'd2);
        chk("to_err",    {127'b0, c_err}, 128'd1);
        chk("to_rdata",  c_rdata, 128'd0);
        chk("to_lat",    128'(cack_cyc - req_cyc), 128'(TO + 1));
        stray_req++;
        seen = 0;
        for (int n = 0; n < 5; n++) begin
            step();
            if (c_ack != '0) seen++;
        end
        chk("stray_noack", 128'(seen), 128'd0);
        chk("stray_err_hold", {127'b0, c_err}, 128'd1);

        // reset while waiting on the controller
        base_req = req_cnt;
        drive(1, 1'b0, ADDR_A, '0);
        for (int n = 0; n < 20; n++) begin
            step();
            if (req_cnt != base_req) break;
        end
        step();
        step();
        chk("mid_busy", {127'b0, busy}, 128'd1);
        reset = 1'b1;
        c_req = '0;
        step();
        chk_zero_outputs("mid");
        reset     = 1'b0;
        ack_delay = 2;
        drive(2, 1'b0, ADDR_A, '0);
        drive(0, 1'b0, ADDR_A, '0);
        wait_ack("post0", idx);
        chk("post_1st", 128'(idx), 128'd0);
        chk("post_data", c_rdata, WDATA_A);
        wait_ack("post1", idx);
        chk("post_2nd", 128'(idx), 128'd2);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
